cc_poscontroller_jug1: RTL

//  Producer of the player-1 position bus that the row/position comparator consumes.
//  - Holds a one-hot position register and moves it on debounced single-cycle pulses.
//  - Takes the comparator's collision flag back as input: decrements lives, then

---
 rtl/cc_poscontroller_jug1_pkg.sv | 17 +
 rtl/cc_penalty_timer.sv | 33 +++
 rtl/cc_poscontroller_jug1.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cc_poscontroller_jug1_pkg.sv
// Shared game definitions used by the player-1 and player-2 position controllers.
// Holds the FSM state encodings, the default bus width, the lives width and
// the default start position.
package cc_poscontroller_jug1_pkg;

  localparam int DATAWIDTH_DEF = 8;
  localparam int LIVES_W = 2;
  localparam logic [DATAWIDTH_DEF-1:0] STARTPOS_DEF = 8'b0001_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } state_e;

endpackage

// File: rtl/cc_penalty_timer.sv
// Loadable down-counter for the HIT phase. It counts down only while enabled
// and stops at zero. It reports when it has reached zero, and it exposes one
// counter bit that is used as the blink phase.
module cc_penalty_timer #(
  parameter int CW       = 26,
  parameter int BLINKBIT = 22
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          enable,
  output logic          zero,
  output logic          blink
);

  logic [CW-1:0] cnt;

  // Load has priority over counting; the counter holds once it reaches zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero  = (cnt == '0);
  assign blink = cnt[BLINKBIT];

endmodule

// File: rtl/cc_poscontroller_jug1.sv
// Player-1 position controller. It keeps a one-hot position register that
// moves on debounced button pulses. A collision reported by the comparator
// costs one life and starts a blinking penalty phase. When the last life is
// lost, the game is over.
module cc_poscontroller_jug1
  import cc_poscontroller_jug1_pkg::*;
#(
  parameter int POSCONTROLLER_DATAWIDTH = DATAWIDTH_DEF,
  parameter logic [POSCONTROLLER_DATAWIDTH-1:0] POSCONTROLLER_STARTPOS = STARTPOS_DEF,
  parameter int POSCONTROLLER_LIVES    = 3,
  parameter int POSCONTROLLER_PENALTY  = 50_000_000,
  parameter int POSCONTROLLER_BLINKBIT = 22
) (
  input  logic                               CC_POSCONTROLLER_JUG1_CLOCK_50,
  input  logic                               CC_POSCONTROLLER_JUG1_RESET_InLow,
  input  logic                               CC_POSCONTROLLER_JUG1_start_InHigh,
  input  logic                               CC_POSCONTROLLER_JUG1_left_InHigh,
  input  logic                               CC_POSCONTROLLER_JUG1_right_InHigh,
  input  logic                               CC_POSCONTROLLER_JUG1_collision,
  output logic [POSCONTROLLER_DATAWIDTH-1:0] CC_POSCONTROLLER_JUG1_posjug1,
  output logic [POSCONTROLLER_DATAWIDTH-1:0] CC_POSCONTROLLER_JUG1_display,
  output logic [LIVES_W-1:0]                 CC_POSCONTROLLER_JUG1_lives,
  output logic                               CC_POSCONTROLLER_JUG1_penalty,
  output logic                               CC_POSCONTROLLER_JUG1_gameover,
  output state_e                             CC_POSCONTROLLER_JUG1_state
);

  localparam int W = POSCONTROLLER_DATAWIDTH;
  // The counter must hold PENALTY-1 and must also contain the blink bit.
  localparam int CW = ($clog2(POSCONTROLLER_PENALTY) > POSCONTROLLER_BLINKBIT) ?
                      $clog2(POSCONTROLLER_PENALTY) : POSCONTROLLER_BLINKBIT + 1;
  localparam logic [CW-1:0] PEN_LOAD = CW'(POSCONTROLLER_PENALTY - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(POSCONTROLLER_LIVES);

  logic clk, rst_n, start, left, right, collision;
  assign clk       = CC_POSCONTROLLER_JUG1_CLOCK_50;
  assign rst_n     = CC_POSCONTROLLER_JUG1_RESET_InLow;
  assign start     = CC_POSCONTROLLER_JUG1_start_InHigh;
  assign left      = CC_POSCONTROLLER_JUG1_left_InHigh;
  assign right     = CC_POSCONTROLLER_JUG1_right_InHigh;
  assign collision = CC_POSCONTROLLER_JUG1_collision;

  state_e               state, state_n;
  logic [W-1:0]         pos, pos_n;
  logic [LIVES_W-1:0]   lives, lives_n;
  logic                 load_c;
  logic                 pen_zero, pen_blink;
  logic [W-1:0]         display_c;

  cc_penalty_timer #(
    .CW       (CW),
    .BLINKBIT (POSCONTROLLER_BLINKBIT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_c),
    .load_val (PEN_LOAD),
    .enable   (state == ST_HIT),
    .zero     (pen_zero),
    .blink    (pen_blink)
  );

  // Register the state, the position and the lives. A reset puts the game back in IDLE immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      pos   <= '0;
      lives <= '0;
    end else begin
      state <= state_n;
      pos   <= pos_n;
      lives <= lives_n;
    end
  end

  // Next state, position and lives. Inside PLAY the priority is start, then collision, then move.
  always_comb begin
    state_n = state;
    pos_n   = pos;
    lives_n = lives;
    load_c  = 1'b0;
    case (state)
      ST_IDLE, ST_OVER: begin
        pos_n = '0;
        if (start) begin
          state_n = ST_PLAY;
          pos_n   = POSCONTROLLER_STARTPOS;
          lives_n = LIVES_INIT;
        end
      end
      ST_PLAY: begin
        if (start) begin
          pos_n   = POSCONTROLLER_STARTPOS;
          lives_n = LIVES_INIT;
        end else if (collision) begin
          if (lives > 2'd1) begin
            state_n = ST_HIT;
            lives_n = lives - 2'd1;
            pos_n   = POSCONTROLLER_STARTPOS;
            load_c  = 1'b1;
          end else begin
            state_n = ST_OVER;
            lives_n = '0;
            pos_n   = '0;
          end
        end else if (left && !right) begin
          if (!pos[W-1]) pos_n = {pos[W-2:0], 1'b0};
        end else if (right && !left) begin
          if (!pos[0]) pos_n = {1'b0, pos[W-1:1]};
        end
      end
      ST_HIT: begin
        if (start) begin
          state_n = ST_PLAY;
          pos_n   = POSCONTROLLER_STARTPOS;
          lives_n = LIVES_INIT;
        end else if (pen_zero) begin
          state_n = ST_PLAY;
        end
      end
      default: begin
        state_n = ST_IDLE;
        pos_n   = '0;
      end
    endcase
  end

  // The LED image is decoded from registered state only. In HIT it blinks with the penalty counter.
  always_comb begin
    display_c = '0;
    if (state == ST_PLAY) display_c = pos;
    else if ((state == ST_HIT) && pen_blink) display_c = pos;
  end

  assign CC_POSCONTROLLER_JUG1_posjug1  = pos;
  assign CC_POSCONTROLLER_JUG1_display  = display_c;
  assign CC_POSCONTROLLER_JUG1_lives    = lives;
  assign CC_POSCONTROLLER_JUG1_penalty  = (state == ST_HIT);
  assign CC_POSCONTROLLER_JUG1_gameover = (state == ST_OVER);
  assign CC_POSCONTROLLER_JUG1_state    = state;

endmodule
